xnor2_serial_match_ctrl: RTL and testbench

//  Bit-serial equality-compare controller that time-shares one xnor2 cell
//  (drive-1 variant) across a WIDTH-bit operand pair.
//  - Accepts a START request and shifts operand bits LSB-first through the

---
 rtl/xnor2_serial_match_ctrl_pkg.sv | 12 +
 rtl/xnor2_serial_match_ctrl_cell.sv | 13 +
 rtl/xnor2_serial_match_ctrl.sv | 111 +++++++++++
 tb/tb_xnor2_serial_match_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/xnor2_serial_match_ctrl_pkg.sv
// xnor2_serial_match_ctrl_pkg: state encodings and index-width derivation
// shared by the serial match controller and its bench.
package xnor2_serial_match_ctrl_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;
   function automatic int idx_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction
endpackage

// File: rtl/xnor2_serial_match_ctrl_cell.sv
// xnor2_serial_match_ctrl_cell: single xnor2 (drive-1) cell slot; ZN = ~(A1 ^ A2),
// with the cell's power pins carried through when present.
module xnor2_serial_match_ctrl_cell (
`ifdef USE_POWER_PINS
   inout  wire  VDD,
   inout  wire  VSS,
`endif
   input  logic A1,
   input  logic A2,
   output logic ZN
);
   assign ZN = ~(A1 ^ A2);
endmodule

// File: rtl/xnor2_serial_match_ctrl.sv
// xnor2_serial_match_ctrl: bit-serial equality compare of A and B, LSB first,
// through one shared xnor2 cell; reports MATCH and the first mismatching index.
module xnor2_serial_match_ctrl
   import xnor2_serial_match_ctrl_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit EARLY_EXIT = 1'b1,
   parameter int IDXW       = idx_width(WIDTH)
) (
`ifdef USE_POWER_PINS
   inout  wire              VDD,
   inout  wire              VSS,
`endif
   input  logic             CLK,
   input  logic             RN,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic             MATCH,
   output logic [IDXW-1:0]  MISMATCH_IDX
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
   logic [IDXW-1:0]  idx_q, idx_d, midx_q, midx_d;
   logic             acc_q, acc_d, match_q, match_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic             bit_eq, last;

   xnor2_serial_match_ctrl_cell u_xnor2 (
`ifdef USE_POWER_PINS
      .VDD (VDD),
      .VSS (VSS),
`endif
      .A1  (a_sh_q[0]),
      .A2  (b_sh_q[0]),
      .ZN  (bit_eq)
   );

   assign last = (idx_q == IDXW'(WIDTH - 1));

   // acc stays 1 until the first zero, so it doubles as the first-miss flag
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      match_d = match_q;
      midx_d  = midx_q;
      case (state_q)
         ST_IDLE: if (START) begin
            a_sh_d  = A;
            b_sh_d  = B;
            idx_d   = '0;
            acc_d   = 1'b1;
            match_d = 1'b0;
            midx_d  = '0;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            idx_d  = idx_q + IDXW'(1);
            acc_d  = acc_q & bit_eq;
            if (acc_q && !bit_eq) midx_d = idx_q;
            if (!bit_eq && EARLY_EXIT) begin
               match_d = 1'b0;
               state_d = ST_DONE;
            end else if (last) begin
               match_d = acc_q & bit_eq;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q <= ST_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         idx_q   <= '0;
         acc_q   <= 1'b0;
         match_q <= 1'b0;
         midx_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         match_q <= match_d;
         midx_q  <= midx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign BUSY         = busy_q;
   assign DONE         = done_q;
   assign MATCH        = match_q;
   assign MISMATCH_IDX = midx_q;
endmodule

// File: tb/tb_xnor2_serial_match_ctrl.sv
// tb_xnor2_serial_match_ctrl: scoreboard bench driving an early-exit and a
// full-compare instance with shared stimulus against a first-difference model.
module tb_xnor2_serial_match_ctrl;
   typedef struct {
      logic     match;
      int       idx;
      int       done_cyc;
      int       busy_len;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RN = 1'b0;
   logic       START = 1'b0;
   logic [7:0] A = '0, B = '0;
   logic [1:0] busy, done, match;
   logic [2:0] midx [2];
   int         cyc = 0;
   int         tests = 0;
   int         fails = 0;
   int         bcnt [2];
   exp_t       q0 [$];
   exp_t       q1 [$];

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   xnor2_serial_match_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut0 (
      .CLK(CLK), .RN(RN), .START(START), .A(A), .B(B),
      .BUSY(busy[0]), .DONE(done[0]), .MATCH(match[0]), .MISMATCH_IDX(midx[0]));
   xnor2_serial_match_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut1 (
      .CLK(CLK), .RN(RN), .START(START), .A(A), .B(B),
      .BUSY(busy[1]), .DONE(done[1]), .MATCH(match[1]), .MISMATCH_IDX(midx[1]));

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: find the first differing bit; early exit stops just after it
   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                  input bit early, input int acc_cyc);
      exp_t e;
      int   first = -1;
      for (int i = 0; i < 8; i++)
         if (a[i] != b[i] && first < 0) first = i;
      e.match    = (first < 0);
      e.idx      = e.match ? 0 : first;
      e.busy_len = (early && !e.match) ? first + 1 : 8;
      e.done_cyc = acc_cyc + e.busy_len;
      return e;
   endfunction

   always @(negedge CLK) begin
      if (!RN) begin
         bcnt[0] = 0;
         bcnt[1] = 0;
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (busy[d]) bcnt[d]++;
            if (done[d]) begin
               if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                  chk($sformatf("dut%0d unexpected_done", d), 1, 0);
               end else begin
                  exp_t e;
                  e = (d == 0) ? q0.pop_front() : q1.pop_front();
                  chk($sformatf("dut%0d match", d), int'(match[d]), int'(e.match));
                  chk($sformatf("dut%0d mismatch_idx", d), int'(midx[d]), e.idx);
                  chk($sformatf("dut%0d done_cycle", d), cyc, e.done_cyc);
                  chk($sformatf("dut%0d busy_cycles", d), bcnt[d], e.busy_len);
                  chk($sformatf("dut%0d busy_at_done", d), int'(busy[d]), 0);
               end
               bcnt[d] = 0;
            end
         end
      end
   end

   task automatic drain(input bit scramble);
      int n = 0;
      forever begin
         @(negedge CLK);
         #1;
         if (q0.size() == 0 && q1.size() == 0) break;
         if (++n > 60) begin
            chk("drain_timeout", q0.size() + q1.size(), 0);
            q0.delete();
            q1.delete();
            break;
         end
         if (scramble) begin
            A = 8'($urandom);
            B = 8'($urandom);
         end
      end
   endtask

   task automatic req(input logic [7:0] a, input logic [7:0] b);
      exp_t e0, e1;
      @(negedge CLK);
      A = a;
      B = b;
      START = 1'b1;
      e0 = model(a, b, 1'b1, cyc + 1);
      e1 = model(a, b, 1'b0, cyc + 1);
      q0.push_back(e0);
      q1.push_back(e1);
      @(negedge CLK);
      START = 1'b0;
      A = ~a;
      B = 8'($urandom);
      drain(1'b1);
      @(negedge CLK);
      chk("dut0 match_retained", int'(match[0]), int'(e0.match));
      chk("dut1 idx_retained", int'(midx[1]), e1.idx);
   endtask

   task automatic chk_zero(input string tag);
      for (int d = 0; d < 2; d++)
         chk($sformatf("%s dut%0d outputs", tag, d),
             int'({busy[d], done[d], match[d], midx[d]}), 0);
   endtask

   initial begin
      #12;
      chk_zero("reset");
      @(negedge CLK);
      RN = 1'b1;
      req(8'hA5, 8'hA5);
      req(8'h0F, 8'h1F);
      req(8'h00, 8'h82);
      // START held: accepts only every 10 cycles, one DONE per accept
      @(negedge CLK);
      A = 8'hFF;
      B = 8'hFF;
      START = 1'b1;
      for (int k = 0; k < 3; k++) begin
         q0.push_back(model(8'hFF, 8'hFF, 1'b1, cyc + 1 + 10 * k));
         q1.push_back(model(8'hFF, 8'hFF, 1'b0, cyc + 1 + 10 * k));
      end
      repeat (30) @(negedge CLK);
      START = 1'b0;
      drain(1'b0);
      // Asynchronous reset during RUN aborts without DONE
      @(negedge CLK);
      A = 8'h55;
      B = 8'h55;
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      repeat (3) @(posedge CLK);
      #2 RN = 1'b0;
      #1 chk_zero("async_reset");
      repeat (2) @(negedge CLK);
      RN = 1'b1;
      repeat (15) @(negedge CLK);
      req(8'h3C, 8'h3C);
      for (int t = 0; t < 30; t++) begin
         logic [7:0] a, b;
         a = 8'($urandom);
         case ($urandom_range(0, 2))
            0: b = a;
            1: b = a ^ (8'h01 << $urandom_range(0, 7));
            default: b = 8'($urandom);
         endcase
         req(a, b);
      end
      chk("leftover_expected", q0.size() + q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
